// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - VGA raster timing bundle (tick, x/y, sync pair, active, frame start)
interface vga_timing_gen_if;
  logic       pixel_tick;
  logic [9:0] x;
  logic [9:0] y;
  logic       hsync;
  logic       vsync;
  logic       active;
  logic       frame_start;

  modport master (
    output pixel_tick, x, y, hsync, vsync, active, frame_start
  );

  modport slave (
    input pixel_tick, x, y, hsync, vsync, active, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - 640x480@60 VGA timing generator; VGA_SYNC_DELAY_EN adds one clock of sync/active delay
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic              clock,
  input  logic              reset_n,
  vga_timing_gen_if.master  vga_o
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_cfg
      $error("vga_timing_gen: totals must be <= 1024 and CLK_DIV >= 1");
    end
  endgenerate

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [9:0]       x_q, x_d;
  logic [9:0]       y_q, y_d;
  logic             frame_q, frame_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             active_q, active_d;

  always_comb begin
    div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    tick_d   = (div_q == DIV_LAST);
    x_d      = x_q;
    y_d      = y_q;
    frame_d  = 1'b0;
    if (tick_q) begin
      if (x_q == H_LAST) begin
        x_d     = '0;
        y_d     = (y_q == V_LAST) ? '0 : y_q + 10'd1;
        frame_d = (y_q == V_LAST);
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    // Decode from next-state counters so the registered flags line up with x_q/y_q.
    hsync_d  = (int'(x_d) >= HS_START && int'(x_d) < HS_END) ? SYNC_POL : ~SYNC_POL;
    vsync_d  = (int'(y_d) >= VS_START && int'(y_d) < VS_END) ? SYNC_POL : ~SYNC_POL;
    active_d = (int'(x_d) < H_ACTIVE) && (int'(y_d) < V_ACTIVE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      tick_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      frame_q  <= 1'b0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      active_q <= 1'b1;
    end else begin
      div_q    <= div_d;
      tick_q   <= tick_d;
      x_q      <= x_d;
      y_q      <= y_d;
      frame_q  <= frame_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
    end
  end

  assign vga_o.pixel_tick  = tick_q;
  assign vga_o.x           = x_q;
  assign vga_o.y           = y_q;
  assign vga_o.frame_start = frame_q;

`ifdef VGA_SYNC_DELAY_EN
  // Matches the downstream box drawer's one-clock registered RGB at the connector.
  logic hsync_dly_q, vsync_dly_q, active_dly_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hsync_dly_q  <= ~SYNC_POL;
      vsync_dly_q  <= ~SYNC_POL;
      active_dly_q <= 1'b0;
    end else begin
      hsync_dly_q  <= hsync_q;
      vsync_dly_q  <= vsync_q;
      active_dly_q <= active_q;
    end
  end

  assign vga_o.hsync  = hsync_dly_q;
  assign vga_o.vsync  = vsync_dly_q;
  assign vga_o.active = active_dly_q;
`else
  assign vga_o.hsync  = hsync_q;
  assign vga_o.vsync  = vsync_q;
  assign vga_o.active = active_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - bench for vga_timing_gen (default 640x480 instance plus a tiny raster instance)
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
  localparam bit DLY = 1'b1;
`else
  localparam bit DLY = 1'b0;
`endif

  typedef struct {
    int d, ha, hf, hs, hb, va, vf, vs, vb;
    bit pol;
  } cfg_t;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       tick, fs, hs, vs, act;
  } obs_t;

  typedef struct {
    int   n;
    obs_t e;
  } vec_t;

  typedef struct {
    int    dut;
    string tag;
    obs_t  e;
    bit    cnt;
    bit    sync;
  } item_t;

  logic clk;
  logic rst_n;

  vga_timing_gen_if d_if ();
  vga_timing_gen_if s_if ();

  vga_timing_gen u_dflt (
    .clock   (clk),
    .reset_n (rst_n),
    .vga_o   (d_if)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
  ) u_small (
    .clock   (clk),
    .reset_n (rst_n),
    .vga_o   (s_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int     checks;
  int     failures;
  int     n;
  bit     tbl_on;
  cfg_t   cd, cs;
  vec_t   tv[12];
  item_t  sb[$];

  task automatic chk10(input string name, input logic [9:0] a, input logic [9:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, a, e);
    end
  endtask

  task automatic chk1(input string name, input logic a, input logic e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, a, e);
    end
  endtask

  task automatic chk_int(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, a, e);
    end
  endtask

  // Closed-form raster position after n clock edges since reset release.
  function automatic obs_t model_raw(cfg_t c, int k);
    obs_t r;
    int p, ht, vt, xi, yi;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    if (k == 0) begin
      xi = 0; yi = 0; r.tick = 1'b0; r.fs = 1'b0;
    end else begin
      p      = (k - 1) / c.d;
      xi     = p % ht;
      yi     = (p / ht) % vt;
      r.tick = ((k - 1) % c.d == c.d - 1);
      r.fs   = ((k - 1) % c.d == 0) && (p > 0) && (p % (ht * vt) == 0);
    end
    r.x   = 10'(xi);
    r.y   = 10'(yi);
    r.hs  = (xi >= c.ha + c.hf && xi < c.ha + c.hf + c.hs) ? c.pol : !c.pol;
    r.vs  = (yi >= c.va + c.vf && yi < c.va + c.vf + c.vs) ? c.pol : !c.pol;
    r.act = (xi < c.ha) && (yi < c.va);
    return r;
  endfunction

  function automatic obs_t model(cfg_t c, int k);
    obs_t r, s;
    r = model_raw(c, k);
    if (DLY) begin
      if (k == 0) begin
        r.hs = !c.pol; r.vs = !c.pol; r.act = 1'b0;
      end else begin
        s = model_raw(c, k - 1);
        r.hs = s.hs; r.vs = s.vs; r.act = s.act;
      end
    end
    return r;
  endfunction

  function automatic vec_t mk(int k, int xv, int yv, logic tk, logic hs, logic act);
    vec_t v;
    v.n = k;
    v.e.x = 10'(xv); v.e.y = 10'(yv);
    v.e.tick = tk; v.e.fs = 1'b0; v.e.hs = hs; v.e.vs = 1'b1; v.e.act = act;
    return v;
  endfunction

  function automatic obs_t sample(int which);
    obs_t a;
    if (which == 0) begin
      a.x = d_if.x; a.y = d_if.y; a.tick = d_if.pixel_tick; a.fs = d_if.frame_start;
      a.hs = d_if.hsync; a.vs = d_if.vsync; a.act = d_if.active;
    end else begin
      a.x = s_if.x; a.y = s_if.y; a.tick = s_if.pixel_tick; a.fs = s_if.frame_start;
      a.hs = s_if.hsync; a.vs = s_if.vsync; a.act = s_if.active;
    end
    return a;
  endfunction

  task automatic push(int which, string tag, obs_t e, bit c, bit s);
    item_t it;
    it.dut = which; it.tag = tag; it.e = e; it.cnt = c; it.sync = s;
    sb.push_back(it);
  endtask

  task automatic step();
    item_t it;
    obs_t  a;
    @(posedge clk);
    if (rst_n) n++;
    push(0, "dflt", model(cd, n), 1'b1, 1'b1);
    push(1, "small", model(cs, n), 1'b1, 1'b1);
    if (tbl_on) begin
      for (int i = 0; i < 12; i++) begin
        if (tv[i].n == n) push(0, $sformatf("vec%0d", i), tv[i].e, 1'b1, 1'b0);
        if (tv[i].n + int'(DLY) == n) push(0, $sformatf("vec%0d", i), tv[i].e, 1'b0, 1'b1);
      end
    end
    @(negedge clk);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      a  = sample(it.dut);
      if (it.cnt) begin
        chk10({it.tag, ".x"}, a.x, it.e.x);
        chk10({it.tag, ".y"}, a.y, it.e.y);
        chk1({it.tag, ".pixel_tick"}, a.tick, it.e.tick);
        chk1({it.tag, ".frame_start"}, a.fs, it.e.fs);
      end
      if (it.sync) begin
        chk1({it.tag, ".hsync"}, a.hs, it.e.hs);
        chk1({it.tag, ".vsync"}, a.vs, it.e.vs);
        chk1({it.tag, ".active"}, a.act, it.e.act);
      end
    end
  endtask

  // Asserts reset between clock edges and checks the asynchronous response.
  task automatic async_reset(string tag);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n = 0;
    chk10({tag, ".async_x"}, d_if.x, 10'd0);
    chk10({tag, ".async_y"}, d_if.y, 10'd0);
    chk1({tag, ".async_hsync"}, d_if.hsync, 1'b1);
    chk1({tag, ".async_vsync"}, d_if.vsync, 1'b1);
    chk1({tag, ".async_tick"}, d_if.pixel_tick, 1'b0);
    chk1({tag, ".async_active"}, d_if.active, !DLY);
    chk1({tag, ".async_small_hsync"}, s_if.hsync, 1'b0);
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  int fs_cnt;
  int vs_cnt;

  initial begin
    checks = 0; failures = 0; n = 0; tbl_on = 1'b0; fs_cnt = 0; vs_cnt = 0;
    cd = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    cs = '{1, 8, 2, 3, 3, 4, 1, 2, 1, 1'b1};
    tv[0]  = mk(1,    0,   0, 1'b0, 1'b1, 1'b1);
    tv[1]  = mk(2,    0,   0, 1'b1, 1'b1, 1'b1);
    tv[2]  = mk(3,    1,   0, 1'b0, 1'b1, 1'b1);
    tv[3]  = mk(1279, 639, 0, 1'b0, 1'b1, 1'b1);
    tv[4]  = mk(1280, 639, 0, 1'b1, 1'b1, 1'b1);
    tv[5]  = mk(1281, 640, 0, 1'b0, 1'b1, 1'b0);
    tv[6]  = mk(1312, 655, 0, 1'b1, 1'b1, 1'b0);
    tv[7]  = mk(1313, 656, 0, 1'b0, 1'b0, 1'b0);
    tv[8]  = mk(1504, 751, 0, 1'b1, 1'b0, 1'b0);
    tv[9]  = mk(1505, 752, 0, 1'b0, 1'b1, 1'b0);
    tv[10] = mk(1600, 799, 0, 1'b1, 1'b1, 1'b0);
    tv[11] = mk(1601, 0,   1, 1'b0, 1'b1, 1'b1);

    rst_n = 1'b0;
    repeat (5) step();
    chk10("reset.x", d_if.x, 10'd0);
    chk10("reset.y", d_if.y, 10'd0);
    chk1("reset.hsync", d_if.hsync, 1'b1);
    chk1("reset.vsync", d_if.vsync, 1'b1);
    chk1("reset.active", d_if.active, !DLY);
    chk1("reset.pixel_tick", d_if.pixel_tick, 1'b0);
    chk1("reset.frame_start", d_if.frame_start, 1'b0);

    rst_n = 1'b1;
    tbl_on = 1'b1;
    repeat (1700) begin
      step();
      if (s_if.frame_start) fs_cnt++;
      if (n <= 128 && s_if.vsync) vs_cnt++;
    end
    tbl_on = 1'b0;
    chk_int("small.frame_start_count", fs_cnt, 13);
    chk_int("small.vsync_clocks_first_frame", vs_cnt, 32);

    async_reset("mid1");
    repeat (601) step();
    chk10("mid1.x_at_300", d_if.x, 10'd300);
    async_reset("mid2");
    repeat (1401) step();
    chk10("mid2.x_at_700", d_if.x, 10'd700);
    chk1("mid2.hsync_in_pulse", d_if.hsync, 1'b0);
    async_reset("mid3");
    repeat (4) step();
    chk10("resume.x", d_if.x, 10'd1);
    chk1("resume.hsync", d_if.hsync, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
